// File: rtl/des_pkg.sv
// Shared types and the DES Initial Permutation table for the input-side deserializer.
package des_pkg;

    typedef logic [63:0] des_block_t;
    typedef logic [31:0] des_half_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } des_state_e;

    // Entry i names the DES input bit position that feeds output position i+1.
    localparam logic [6:0] IP_TABLE [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

endpackage

// File: rtl/des_ip_deserializer_if.sv
// Byte-side and block-side handshakes of the IP deserializer.
interface des_ip_deserializer_if;
    import des_pkg::*;

    logic      byte_valid;
    logic [7:0] byte_data;
    logic      byte_ready;
    logic      blk_valid;
    logic      blk_ready;
    des_half_t l0;
    des_half_t r0;

    modport master (
        output byte_valid, byte_data, blk_ready,
        input  byte_ready, blk_valid, l0, r0
    );

    modport slave (
        input  byte_valid, byte_data, blk_ready,
        output byte_ready, blk_valid, l0, r0
    );

endinterface

// File: rtl/des_initial_permutation.sv
// Combinational DES Initial Permutation; inverse of the final-permutation stage.
module des_initial_permutation
    import des_pkg::*;
(
    input  des_block_t blk_i,
    output des_block_t blk_o
);

    // DES bit position p lives at vector index 64-p.
    for (genvar i = 0; i < 64; i++) begin : g_bit
        localparam int SRC = 32'sd64 - int'(IP_TABLE[i]);
        assign blk_o[63-i] = blk_i[SRC];
    end

endmodule

// File: rtl/des_ip_deserializer.sv
// Assembles eight bytes into a 64-bit block, applies IP and offers L0/R0 through
// a valid/ready output register; one spare block may wait in the assembly register.
module des_ip_deserializer
    import des_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_clear,
    des_ip_deserializer_if.slave bus,
    output logic [CNT_W-1:0]     blk_count
);

    des_state_e       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    des_block_t       asm_q, asm_d;
    des_block_t       perm_s;
    logic             live_q;
    logic             vld_q;
    des_half_t        l0_q, r0_q;
    logic [CNT_W-1:0] cnt_q;
    logic             byte_ready_s;
    logic             xfer_s;
    logic             out_free_s;
    logic             load_s;

    // The permutation sees the next assembly value so the 8th byte reaches l0/r0 at once.
    des_initial_permutation u_ip (
        .blk_i (asm_d),
        .blk_o (perm_s)
    );

    // Next-state, byte placement and output-load decision.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        load_s       = 1'b0;
        out_free_s   = !vld_q || bus.blk_ready;
        byte_ready_s = (state_q == FILL) && live_q && !sync_clear;
        xfer_s       = bus.byte_valid && byte_ready_s;

        for (int j = 0; j < 8; j++) begin
            asm_d[8*j +: 8] = (xfer_s && (idx_q == (MSB_FIRST ? 3'(7 - j) : 3'(j))))
                              ? bus.byte_data : asm_q[8*j +: 8];
        end

        case (state_q)
            FILL: begin
                if (sync_clear) begin
                    idx_d = 3'd0;
                end else if (xfer_s) begin
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
                        if (out_free_s) begin
                            load_s = 1'b1;
                        end else begin
                            state_d = FULL;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            FULL: begin
                idx_d = 3'd0;
                if (sync_clear) begin
                    state_d = FILL;
                end else if (out_free_s) begin
                    load_s  = 1'b1;
                    state_d = FILL;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = 3'd0;
            end
        endcase
    end

    // FSM state, byte index and assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= 3'd0;
            asm_q   <= 64'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            live_q  <= 1'b1;
        end
    end

    // Output register and delivered-block counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            l0_q  <= 32'd0;
            r0_q  <= 32'd0;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (load_s) begin
                vld_q <= 1'b1;
                l0_q  <= perm_s[63:32];
                r0_q  <= perm_s[31:0];
            end else if (bus.blk_ready) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_q;
            end
            if (vld_q && bus.blk_ready) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    assign bus.byte_ready = byte_ready_s;
    assign bus.blk_valid  = vld_q;
    assign bus.l0         = l0_q;
    assign bus.r0         = r0_q;
    assign blk_count      = cnt_q;

endmodule

// File: tb/tb_des_ip_deserializer.sv
// Directed bench for des_ip_deserializer: MSB-first instance with 16-bit counter,
// LSB-first instance with a 4-bit counter so the counter wrap is reached quickly.
module tb_des_ip_deserializer;

    logic clk;
    logic rst_n;
    logic sc0;
    logic sc1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    int n_tests;
    int n_fail;
    int drops;
    logic [63:0] v0;
    logic [63:0] v1;

    des_ip_deserializer_if bus0 ();
    des_ip_deserializer_if bus1 ();

    des_ip_deserializer #(.MSB_FIRST(1'b1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sync_clear(sc0), .bus(bus0), .blk_count(cnt0));

    des_ip_deserializer #(.MSB_FIRST(1'b0), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sync_clear(sc1), .bus(bus1), .blk_count(cnt1));

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ip_model(input logic [63:0] b);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = b[64-IP_T[i]];
        return r;
    endfunction

    function automatic logic [63:0] fp_model(input logic [63:0] b);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = b[64-FP_T[i]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus0.byte_valid = 1'b0; bus0.byte_data = 8'h00; bus0.blk_ready = 1'b0;
        bus1.byte_valid = 1'b0; bus1.byte_data = 8'h00; bus1.blk_ready = 1'b0;
        sc0 = 1'b0; sc1 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Sends one block MSB-first into dut0, counting any byte_ready drop.
    task automatic send0(input logic [63:0] blk, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            bus0.byte_valid = 1'b1;
            bus0.byte_data  = blk[63-8*k -: 8];
            #0;
            if (bus0.byte_ready !== 1'b1) drops++;
            step();
        end
        bus0.byte_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; drops = 0;
        rst_n = 1'b0; sc0 = 1'b0; sc1 = 1'b0;
        bus0.byte_valid = 1'b0; bus0.byte_data = 8'h00; bus0.blk_ready = 1'b0;
        bus1.byte_valid = 1'b0; bus1.byte_data = 8'h00; bus1.blk_ready = 1'b0;
        #1;
        check("rst_byte_ready", {63'd0, bus0.byte_ready}, 64'd0);
        check("rst_blk_valid",  {63'd0, bus0.blk_valid},  64'd0);
        check("rst_l0r0",       {bus0.l0, bus0.r0},       64'd0);
        check("rst_count",      {48'd0, cnt0},            64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_byte_ready", {63'd0, bus0.byte_ready}, 64'd1);

        // Single block, back-to-back bytes.
        bus0.blk_ready = 1'b1;
        send0(64'h0123456789ABCDEF, 8);
        check("blk1_valid", {63'd0, bus0.blk_valid}, 64'd1);
        check("blk1_l0",    {32'd0, bus0.l0}, 64'h00000000CC00CCFF);
        check("blk1_r0",    {32'd0, bus0.r0}, 64'h00000000F0AAF0AA);
        step();
        check("blk1_count", {48'd0, cnt0}, 64'd1);
        check("blk1_valid_drop", {63'd0, bus0.blk_valid}, 64'd0);

        // Two consecutive blocks without bubbles.
        do_reset();
        bus0.blk_ready = 1'b1;
        drops = 0;
        send0(64'h0123456789ABCDEF, 8);
        check("two_first_l0", {32'd0, bus0.l0}, 64'h00000000CC00CCFF);
        send0(64'h0000000000000000, 8);
        check("two_no_drop", 64'(drops), 64'd0);
        check("two_second_l0r0", {bus0.l0, bus0.r0}, 64'd0);
        check("two_second_valid", {63'd0, bus0.blk_valid}, 64'd1);
        step();
        check("two_count", {48'd0, cnt0}, 64'd2);

        // Back-pressure: second block parks in FULL.
        do_reset();
        send0(64'h0123456789ABCDEF, 8);
        bus0.byte_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus0.byte_data = 8'hFF;
            step();
            check("bp_hold_l0", {32'd0, bus0.l0}, 64'h00000000CC00CCFF);
        end
        check("bp_full_byte_ready", {63'd0, bus0.byte_ready}, 64'd0);
        check("bp_hold_r0", {32'd0, bus0.r0}, 64'h00000000F0AAF0AA);
        check("bp_valid", {63'd0, bus0.blk_valid}, 64'd1);
        bus0.byte_valid = 1'b0;
        bus0.blk_ready = 1'b1;
        step();
        bus0.blk_ready = 1'b0;
        check("bp_reload_valid", {63'd0, bus0.blk_valid}, 64'd1);
        check("bp_reload_l0r0", {bus0.l0, bus0.r0}, 64'hFFFFFFFFFFFFFFFF);
        check("bp_reload_count", {48'd0, cnt0}, 64'd1);
        check("bp_fill_byte_ready", {63'd0, bus0.byte_ready}, 64'd1);
        step();
        check("bp_stable_valid", {63'd0, bus0.blk_valid}, 64'd1);
        check("bp_stable_count", {48'd0, cnt0}, 64'd1);

        // sync_clear drops the presented byte and restarts the index.
        do_reset();
        bus0.blk_ready = 1'b1;
        send0(64'hFFFFFFFFFFFFFFFF, 3);
        sc0 = 1'b1;
        bus0.byte_valid = 1'b1;
        bus0.byte_data  = 8'h5A;
        #0;
        check("sc_byte_ready", {63'd0, bus0.byte_ready}, 64'd0);
        step();
        sc0 = 1'b0;
        send0(64'h0123456789ABCDEF, 7);
        check("sc_not_early", {63'd0, bus0.blk_valid}, 64'd0);
        bus0.byte_valid = 1'b1;
        bus0.byte_data  = 8'hEF;
        step();
        bus0.byte_valid = 1'b0;
        check("sc_valid", {63'd0, bus0.blk_valid}, 64'd1);
        check("sc_l0r0", {bus0.l0, bus0.r0}, 64'hCC00CCFFF0AAF0AA);

        // Asynchronous reset mid-block with a block pending on the output.
        do_reset();
        send0(64'h0123456789ABCDEF, 8);
        send0(64'hFFFFFFFFFFFFFFFF, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, bus0.blk_valid}, 64'd0);
        check("arst_l0r0", {bus0.l0, bus0.r0}, 64'd0);
        check("arst_byte_ready", {63'd0, bus0.byte_ready}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        bus0.blk_ready = 1'b1;
        send0(64'h0123456789ABCDEF, 8);
        check("arst_fresh_l0r0", {bus0.l0, bus0.r0}, 64'hCC00CCFFF0AAF0AA);

        // Random blocks on both byte orders; FP undoes IP; 4-bit counter wraps.
        do_reset();
        bus0.blk_ready = 1'b1;
        bus1.blk_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            v0 = {$urandom, $urandom};
            v1 = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) begin
                bus0.byte_valid = 1'b1;
                bus0.byte_data  = v0[63-8*k -: 8];
                bus1.byte_valid = 1'b1;
                bus1.byte_data  = v1[8*k +: 8];
                step();
            end
            bus0.byte_valid = 1'b0;
            bus1.byte_valid = 1'b0;
            check("rnd_msb_ip", {bus0.l0, bus0.r0}, ip_model(v0));
            check("rnd_msb_fp", fp_model({bus0.l0, bus0.r0}), v0);
            check("rnd_lsb_ip", {bus1.l0, bus1.r0}, ip_model(v1));
            check("rnd_lsb_fp", fp_model({bus1.l0, bus1.r0}), v1);
            check("rnd_cnt_wrap", {60'd0, cnt1}, 64'(n % 16));
        end
        step();
        check("final_cnt0", {48'd0, cnt0}, 64'd20);
        check("final_cnt1", {60'd0, cnt1}, 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
